// File: rtl/mul_arbiter.sv
// Purpose : round-robin arbiter sharing one unsigned_mul between two requesters.
// Latency : mul_start one cycle after the sampling IDLE cycle; done one cycle after mul_done.
// Backpressure: requests are sampled only in IDLE; a request holds until its done pulse.
//
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   req0/req1, m0/q0, m1/q1 requests and their 16-bit operands (stable while req high)
//   done0/done1             single-cycle completion pulse to the granted requester
//   rsp_result, err         32-bit product (held until next capture), timeout flag
//   busy                    high whenever the FSM is not IDLE
//   mul_m/mul_q, mul_start  operands and start pulse to the shared multiplier
//   mul_result, mul_done    product and completion from the shared multiplier
//
// Optional feature: define MUL_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYC cycles,
// returning 32'hFFFF_FFFF with err=1. Without it the block waits on mul_done forever.
module mul_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] m0,
    input  logic [15:0] q0,
    input  logic [15:0] m1,
    input  logic [15:0] q1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rsp_result,
    output logic        err,
    output logic        busy,
    output logic [15:0] mul_m,
    output logic [15:0] mul_q,
    output logic        mul_start,
    input  logic [31:0] mul_result,
    input  logic        mul_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;     // requester served most recently
    logic        grant_q, grant_d;   // requester owning the current operation
    logic [15:0] m_q, m_d;
    logic [15:0] qop_q, qop_d;
    logic [31:0] rsp_q, rsp_d;

    // A zero timeout would make the WAIT state meaningless.
    if (TIMEOUT_CYC < 1) begin : g_timeout_range
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef MUL_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;  // WAIT cycles elapsed, starting at 0
    logic             err_q, err_d;  // current response is a timeout abort
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        m_d     = m_q;
        qop_d   = qop_q;
        rsp_d   = rsp_q;
`ifdef MUL_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins.
                    grant_d = (req0 && req1) ? ~last_q : req1;
                    m_d     = grant_d ? m1 : m0;
                    qop_d   = grant_d ? q1 : q0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // mul_done is deliberately not looked at here.
                state_d = S_WAIT;
`ifdef MUL_TIMEOUT_EN
                cnt_d   = '0;
                err_d   = 1'b0;
`endif
            end
            S_WAIT: begin
                if (mul_done) begin
                    rsp_d   = mul_result;
                    state_d = S_RESP;
                end
`ifdef MUL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    rsp_d   = 32'hFFFF_FFFF;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_RESP: begin
                last_d  = grant_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            m_q     <= 16'h0000;
            qop_q   <= 16'h0000;
            rsp_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            m_q     <= m_d;
            qop_q   <= qop_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef MUL_TIMEOUT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = (state_q == S_RESP) && err_q;
`else
    assign err = 1'b0;
`endif

    // Pulses decode straight from the state register so reset clears them at once.
    assign mul_start  = (state_q == S_ISSUE);
    assign done0      = (state_q == S_RESP) && !grant_q;
    assign done1      = (state_q == S_RESP) &&  grant_q;
    assign busy       = (state_q != S_IDLE);
    assign mul_m      = m_q;
    assign mul_q      = qop_q;
    assign rsp_result = rsp_q;

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] m0 = '0, q0 = '0, m1 = '0, q1 = '0;
    logic        done0, done1, err, busy, mul_start;
    logic [31:0] rsp_result;
    logic [15:0] mul_m, mul_q;
    logic [31:0] mul_result;
    logic        mul_done;

    // Multiplier environment: an automatic responder plus a manual override.
    logic        env_done = 1'b0;
    logic [31:0] env_res = '0;
    logic        force_done = 1'b0;
    logic [31:0] force_res = '0;
    bit          auto_mul = 1'b1;

    assign mul_done   = env_done | force_done;
    assign mul_result = force_done ? force_res : env_res;

    int total = 0;
    int bad = 0;
    int last_model = 1;  // reference: requester served most recently

    always #5 clk = ~clk;

    mul_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .n_rst(n_rst),
        .req0(req0), .req1(req1),
        .m0(m0), .q0(q0), .m1(m1), .q1(q1),
        .done0(done0), .done1(done1),
        .rsp_result(rsp_result), .err(err), .busy(busy),
        .mul_m(mul_m), .mul_q(mul_q), .mul_start(mul_start),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    // Behaves like the shared multiplier: answers 1..4 cycles after the start pulse.
    initial begin : mul_env
        int lat;
        forever begin
            @(negedge clk);
            if (auto_mul && mul_start) begin
                lat = $urandom_range(1, 4);
                repeat (lat) @(negedge clk);
                if (auto_mul) begin
                    env_res  = {16'h0, mul_m} * {16'h0, mul_q};
                    env_done = 1'b1;
                    @(negedge clk);
                    env_done = 1'b0;
                end
            end
        end
    end

    function automatic int pick(bit r0, bit r1);
        if (r0 && r1) return (last_model == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    function automatic logic [31:0] prod(logic [15:0] a, logic [15:0] b);
        return {16'h0, a} * {16'h0, b};
    endfunction

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0 || done1) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mul_start) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    // n0/n1 = how many services each requester wants; req stays high until the last one.
    task automatic run_ops(input int n0, input int n1, input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1, input string tag);
        int c0, c1, who;
        bit got;
        logic [31:0] exp_res;
        c0 = n0; c1 = n1;
        m0 = a0; q0 = b0; m1 = a1; q1 = b1;
        @(negedge clk);
        req0 = (c0 > 0);
        req1 = (c1 > 0);
        while (c0 > 0 || c1 > 0) begin
            wait_done(got);
            total++;
            if (!got) begin
                bad++;
                $display("FAIL %s_timeout: no done pulse, expected one", tag);
                req0 = 1'b0; req1 = 1'b0;
                return;
            end
            who = pick(c0 > 0, c1 > 0);
            exp_res = who ? prod(a1, b1) : prod(a0, b0);
            total++;
            if ({done1, done0} !== ((who == 1) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL %s_grant: done1/done0=%b expected requester %0d", tag, {done1, done0}, who);
            end
            total++;
            if (rsp_result !== exp_res) begin
                bad++;
                $display("FAIL %s_result: got %h expected %h", tag, rsp_result, exp_res);
            end
            total++;
            if (err !== 1'b0) begin
                bad++;
                $display("FAIL %s_err: got %b expected 0", tag, err);
            end
            last_model = who;
            if (who == 1) begin c1--; req1 = (c1 > 0); end
            else          begin c0--; req0 = (c0 > 0); end
        end
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        #1;
        total++;
        if ({busy, done0, done1, err, mul_start} !== 5'b0 || mul_m !== 16'h0 || mul_q !== 16'h0
            || rsp_result !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: busy/d0/d1/err/start=%b m=%h q=%h res=%h expected all zero",
                     {busy, done0, done1, err, mul_start}, mul_m, mul_q, rsp_result);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        last_model = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single(input bit who, input logic [15:0] a, input logic [15:0] b, input string tag);
        bit got;
        if (who) begin m1 = a; q1 = b; req1 = 1'b1; end
        else     begin m0 = a; q0 = b; req0 = 1'b1; end
        @(negedge clk);  // the edge just passed was the sampling IDLE cycle
        total++;
        if (mul_start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_start: mul_start=%b busy=%b expected 1 1", tag, mul_start, busy);
        end
        total++;
        if (mul_m !== a || mul_q !== b) begin
            bad++;
            $display("FAIL %s_operands: mul_m=%0d mul_q=%0d expected %0d %0d", tag, mul_m, mul_q, a, b);
        end
        wait_done(got);
        total++;
        if (!got || {done1, done0} !== (who ? 2'b10 : 2'b01) || rsp_result !== prod(a, b) || err !== 1'b0) begin
            bad++;
            $display("FAIL %s_done: got=%b d1d0=%b res=%h err=%b expected res %h err 0",
                     tag, got, {done1, done0}, rsp_result, err, prod(a, b));
        end
        req0 = 1'b0; req1 = 1'b0;
        last_model = who;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rsp_result !== prod(a, b)) begin
            bad++;
            $display("FAIL %s_hold: busy=%b res=%h expected 0 %h", tag, busy, rsp_result, prod(a, b));
        end
    endtask

    task automatic test_tie();
        // Requester 0 asks twice, so the second tie must go to requester 1.
        run_ops(2, 1, 16'd3, 16'd4, 16'd13, 16'd13, "tie");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_done_in_issue();
        bit got;
        auto_mul = 1'b0;
        m0 = 16'd5; q0 = 16'd7; req0 = 1'b1;
        wait_start(got);
        force_res = 32'h0000_DEAD; force_done = 1'b1;   // spurious, during ISSUE
        @(negedge clk);
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (!got || done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL issue_done_ignored: started=%b d0=%b d1=%b busy=%b expected 1 0 0 1",
                     got, done0, done1, busy);
        end
        force_res = 32'd35; force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        total++;
        if (done0 !== 1'b1 || rsp_result !== 32'd35) begin
            bad++;
            $display("FAIL issue_wait_done: d0=%b res=%h expected 1 00000023", done0, rsp_result);
        end
        req0 = 1'b0;
        last_model = 0;
        auto_mul = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got;
        int seen;
        auto_mul = 1'b0;
        m1 = 16'd9; q1 = 16'd9; req1 = 1'b1;
        wait_start(got);
        @(negedge clk);  // now in WAIT
        #2 n_rst = 1'b0;
        #1;
        total++;
        if (!got || {busy, done0, done1, err, mul_start} !== 5'b0 || mul_m !== 16'h0
            || mul_q !== 16'h0 || rsp_result !== 32'h0) begin
            bad++;
            $display("FAIL midreset_outputs: busy/d0/d1/err/start=%b m=%h q=%h res=%h expected all zero",
                     {busy, done0, done1, err, mul_start}, mul_m, mul_q, rsp_result);
        end
        req1 = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        last_model = 1;
        force_res = 32'd81; force_done = 1'b1;   // stale completion
        @(negedge clk);
        force_done = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done0 || done1 || busy) seen++;
        end
        total++;
        if (seen != 0 || rsp_result !== 32'h0) begin
            bad++;
            $display("FAIL midreset_stale: activity cycles=%0d res=%h expected 0 00000000", seen, rsp_result);
        end
        auto_mul = 1'b1;
    endtask

    task automatic test_random();
        int n0, n1;
        for (int i = 0; i < 20; i++) begin
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 == 0 && n1 == 0) n0 = 1;
            run_ops(n0, n1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), "rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

`ifdef MUL_TIMEOUT_EN
    task automatic test_timeout();
        bit got;
        int early;
        auto_mul = 1'b0;
        m0 = 16'd2; q0 = 16'd3; req0 = 1'b1;
        wait_start(got);
        early = 0;
        repeat (8) begin   // eight WAIT cycles with no response
            @(negedge clk);
            if (done0 || done1 || err) early++;
        end
        total++;
        if (!got || early != 0) begin
            bad++;
            $display("FAIL timeout_early: started=%b early cycles=%0d expected 1 0", got, early);
        end
        @(negedge clk);
        total++;
        if (done0 !== 1'b1 || err !== 1'b1 || rsp_result !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL timeout_resp: d0=%b err=%b res=%h expected 1 1 ffffffff", done0, err, rsp_result);
        end
        req0 = 1'b0;
        last_model = 0;
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err_clear: err=%b expected 0", err);
        end
        auto_mul = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single(1'b0, 16'h3, 16'h4, "single0");
        test_single(1'b1, 16'd13, 16'd13, "single1");
        test_tie();
        test_done_in_issue();
        test_reset_mid();
        test_random();
`ifdef MUL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
